// File: rtl/div_period_monitor.sv
// -----------------------------------------------------------------------------
// div_period_monitor
//
// Watches the divided clock from the divide-by-2 clock divider. The divided
// clock is sampled in the same fast clk domain. The monitor measures the period
// (rise to rise) and the high time (rise to fall) in clk cycles. It compares
// each period against EXP_PERIOD/EXP_HIGH and asserts `locked` after LOCK_CNT
// matching periods in a row. A mismatch while locked, or a stuck input, gives a
// one-cycle `err` pulse.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-low reset
//   en         monitor enable; low forces IDLE
//   in_sig     divided clock under test, synchronous to clk
//   period_out last measured period (clk cycles)
//   high_out   last measured high time (clk cycles)
//   meas_valid one-cycle pulse when period_out/high_out update
//   locked     level, lock achieved
//   err        one-cycle pulse on mismatch-while-locked or timeout
//
// LOCK_CNT must lie in 1..15 (match_cnt is 4 bits wide).
// -----------------------------------------------------------------------------
module div_period_monitor #(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned EXP_PERIOD = 2,
   parameter int unsigned EXP_HIGH   = 1,
   parameter int unsigned LOCK_CNT   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             in_sig,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] high_out,
   output logic             meas_valid,
   output logic             locked,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] EXP_P    = CNT_W'(EXP_PERIOD);
   localparam logic [CNT_W-1:0] EXP_H    = CNT_W'(EXP_HIGH);
   localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARM   = 2'd1;
   localparam logic [1:0] ST_TRACK = 2'd2;
   localparam logic [1:0] ST_LOCK  = 2'd3;

   logic             in_d;
   logic [CNT_W-1:0] period_cnt, period_cnt_nxt;
   logic [CNT_W-1:0] high_cnt, high_cnt_nxt;
   logic [CNT_W-1:0] high_lat, high_lat_nxt;
   logic             high_seen, high_seen_nxt;
   logic [3:0]       match_cnt, match_cnt_nxt;
   logic [1:0]       state, state_nxt;
   logic             meas, err_nxt;

   logic rise, fall, active, timeout, match;

   // in_d resets to 0, so in_sig=1 on the first clk after reset is a rise.
   assign rise    = in_sig & ~in_d;
   assign fall    = ~in_sig & in_d;
   assign active  = (state != ST_IDLE);
   assign timeout = active && (period_cnt == CNT_MAX);
   assign match   = (period_cnt == EXP_P) && high_seen && (high_lat == EXP_H);

   // Measurement counters run in every state; only the FSM decides whether a
   // rise produces a measurement.
   always_comb begin
      period_cnt_nxt = period_cnt;
      high_cnt_nxt   = high_cnt;
      high_lat_nxt   = high_lat;
      high_seen_nxt  = high_seen;

      if (rise) begin
         period_cnt_nxt = CNT_ONE;
      end else if (period_cnt != CNT_MAX) begin
         period_cnt_nxt = period_cnt + CNT_ONE;
      end

      if (rise) begin
         high_cnt_nxt  = CNT_ONE;
         high_seen_nxt = 1'b0;
      end else if (in_sig && (high_cnt != CNT_MAX)) begin
         high_cnt_nxt = high_cnt + CNT_ONE;
      end

      if (fall) begin
         high_lat_nxt  = high_cnt;
         high_seen_nxt = 1'b1;
      end
   end

   // Priority: en=0, then timeout, then rise measurement.
   always_comb begin
      state_nxt     = state;
      match_cnt_nxt = match_cnt;
      meas          = 1'b0;
      err_nxt       = 1'b0;

      if (!en) begin
         state_nxt     = ST_IDLE;
         match_cnt_nxt = 4'd0;
      end else if (timeout) begin
         state_nxt     = ST_IDLE;
         match_cnt_nxt = 4'd0;
         err_nxt       = 1'b1;
      end else if (rise) begin
         case (state)
            ST_IDLE: begin
               // First rise only starts timing.
               state_nxt = ST_ARM;
            end
            ST_ARM: begin
               meas = 1'b1;
               if (match) begin
                  match_cnt_nxt = 4'd1;
                  state_nxt     = (LOCK_TGT == 4'd1) ? ST_LOCK : ST_TRACK;
               end else begin
                  match_cnt_nxt = 4'd0;
                  state_nxt     = ST_TRACK;
               end
            end
            ST_TRACK: begin
               meas = 1'b1;
               if (match) begin
                  match_cnt_nxt = match_cnt + 4'd1;
                  if (match_cnt + 4'd1 == LOCK_TGT) begin
                     state_nxt = ST_LOCK;
                  end
               end else begin
                  match_cnt_nxt = 4'd0;
               end
            end
            default: begin // ST_LOCK
               meas = 1'b1;
               if (!match) begin
                  state_nxt     = ST_TRACK;
                  match_cnt_nxt = 4'd0;
                  err_nxt       = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_d       <= 1'b0;
         period_cnt <= '0;
         high_cnt   <= '0;
         high_lat   <= '0;
         high_seen  <= 1'b0;
         match_cnt  <= 4'd0;
         state      <= ST_IDLE;
         period_out <= '0;
         high_out   <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         err        <= 1'b0;
      end else begin
         in_d       <= in_sig;
         period_cnt <= period_cnt_nxt;
         high_cnt   <= high_cnt_nxt;
         high_lat   <= high_lat_nxt;
         high_seen  <= high_seen_nxt;
         match_cnt  <= match_cnt_nxt;
         state      <= state_nxt;
         meas_valid <= meas;
         locked     <= (state_nxt == ST_LOCK);
         err        <= err_nxt;
         // Outputs hold their last values while idle or disabled.
         if (meas) begin
            period_out <= period_cnt;
            high_out   <= high_lat;
         end
      end
   end

endmodule
